// File: rtl/sdram_pattern_writer.sv
// sdram_pattern_writer: programs the SDRAM write master and streams a pattern.
// Define SDRAM_PATTERN_LFSR_EN to use a 16-bit Galois LFSR instead of a counter.
`timescale 1ns/1ps
module sdram_pattern_writer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_LOCATION = 0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length_bytes,
  input  logic [15:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_pushed,
  output logic                  wr_ctrl_fixed_location,
  output logic [ADDR_WIDTH-1:0] wr_ctrl_write_base,
  output logic [ADDR_WIDTH-1:0] wr_ctrl_write_length,
  output logic                  wr_ctrl_go,
  input  logic                  wr_ctrl_done,
  output logic                  wr_user_write_buffer,
  output logic [DATA_WIDTH-1:0] wr_user_buffer_input_data,
  input  logic                  wr_user_buffer_full
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BPW);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] words_q, words_d;
  logic [15:0]           pat_q, pat_d;
  logic                  seen_q, seen_d;
  logic [ADDR_WIDTH-1:0] len_w;
  logic                  push;

  function automatic logic [15:0] pat_next(input logic [15:0] p);
`ifdef SDRAM_PATTERN_LFSR_EN
    pat_next = (p >> 1) ^ (p[0] ? 16'hB400 : 16'h0000);
`else
    pat_next = p + 16'd1;
`endif
  endfunction

  function automatic logic [15:0] pat_seed(input logic [15:0] s);
`ifdef SDRAM_PATTERN_LFSR_EN
    // an all-zero LFSR would lock up
    pat_seed = (s == 16'h0000) ? 16'hACE1 : s;
`else
    pat_seed = s;
`endif
  endfunction

  assign len_w = (length_bytes >> SHIFT) << SHIFT;
  assign push  = (state_q == ST_STREAM) &&
                 (rem_q != '0) &&
                 !wr_user_buffer_full;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    rem_d   = rem_q;
    words_d = words_q;
    pat_d   = pat_q;
    seen_d  = seen_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && wr_ctrl_done) begin
          base_d  = base_addr;
          len_d   = len_w;
          rem_d   = length_bytes >> SHIFT;
          pat_d   = pat_seed(seed);
          words_d = '0;
          state_d = (len_w == '0) ? ST_DONE : ST_GO;
        end
      end
      ST_GO: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!wr_ctrl_done) seen_d = 1'b1;
        if (push) begin
          pat_d   = pat_next(pat_q);
          rem_d   = rem_q - ADDR_WIDTH'(1);
          words_d = words_q + ADDR_WIDTH'(1);
        end
        if (rem_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!wr_ctrl_done) seen_d = 1'b1;
        // the done flag right after go may be stale; wait for a busy phase
        if (seen_q && wr_ctrl_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        seen_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      pat_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      pat_q   <= pat_d;
      seen_q  <= seen_d;
    end
  end

  assign busy                      = (state_q != ST_IDLE);
  assign done                      = (state_q == ST_DONE);
  assign words_pushed              = words_q;
  assign wr_ctrl_fixed_location    = (FIXED_LOCATION != 0);
  assign wr_ctrl_write_base        = base_q;
  assign wr_ctrl_write_length      = len_q;
  assign wr_ctrl_go                = (state_q == ST_GO);
  assign wr_user_write_buffer      = push;
  assign wr_user_buffer_input_data = DATA_WIDTH'(pat_q);

endmodule

// File: tb/tb_sdram_pattern_writer.sv
// tb_sdram_pattern_writer: table-driven and randomized bench for the
// SDRAM pattern writer, with a behavioural write-master model.
`timescale 1ns/1ps
module tb_sdram_pattern_writer;

  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length_bytes = '0;
  logic [15:0]   seed = '0;
  logic          busy, done;
  logic [AW-1:0] words_pushed;
  logic          wr_ctrl_fixed_location;
  logic [AW-1:0] wr_ctrl_write_base, wr_ctrl_write_length;
  logic          wr_ctrl_go;
  logic          wr_ctrl_done = 1'b1;
  logic          wr_user_write_buffer;
  logic [DW-1:0] wr_user_buffer_input_data;
  logic          wr_user_buffer_full = 1'b0;

  int checks = 0;
  int passes = 0;
  logic [15:0] got_q[$];

  typedef struct {
    logic [31:0] base;
    logic [31:0] len;
    logic [15:0] seed;
    int          stale;
    int          busyc;
    int          fmode;
    bit          poke;
    logic [31:0] exp_lenw;
    logic [31:0] exp_words;
  } vec_t;

  vec_t tbl[8];

  always #5 clk_clk = ~clk_clk;

  sdram_pattern_writer dut (
    .clk_clk                   (clk_clk),
    .reset_reset               (reset_reset),
    .start                     (start),
    .base_addr                 (base_addr),
    .length_bytes              (length_bytes),
    .seed                      (seed),
    .busy                      (busy),
    .done                      (done),
    .words_pushed              (words_pushed),
    .wr_ctrl_fixed_location    (wr_ctrl_fixed_location),
    .wr_ctrl_write_base        (wr_ctrl_write_base),
    .wr_ctrl_write_length      (wr_ctrl_write_length),
    .wr_ctrl_go                (wr_ctrl_go),
    .wr_ctrl_done              (wr_ctrl_done),
    .wr_user_write_buffer      (wr_user_write_buffer),
    .wr_user_buffer_input_data (wr_user_buffer_input_data),
    .wr_user_buffer_full       (wr_user_buffer_full)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // word i of a transfer started with seed s
  function automatic logic [15:0] ref_word(input logic [15:0] s, input int i);
    logic [15:0] p;
`ifdef SDRAM_PATTERN_LFSR_EN
    p = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < i; k++)
      p = {1'b0, p[15:1]} ^ (p[0] ? 16'hB400 : 16'h0000);
`else
    p = s + 16'(i);
`endif
    return p;
  endfunction

  task automatic xfer(input vec_t v);
    int gocyc = -1;
    int lastpush = -1;
    int upat = -1;
    int donecyc = -1;
    int pushes = 0;
    int gos = 0;
    int hold = 0;
    int pc = 0;
    int viol = 0;
    int busylow = 0;
    int badbase = 0;
    int expdone;
    bit poked = 0;
    got_q.delete();
    @(posedge clk_clk); #1;
    base_addr = v.base;
    length_bytes = v.len;
    seed = v.seed;
    start = 1'b1;
    wr_ctrl_done = 1'b1;
    wr_user_buffer_full = 1'b0;
    @(posedge clk_clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && donecyc < 0; cyc++) begin
      start = 1'b0;
      if (v.poke && !poked && pushes == 2) begin
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
        length_bytes = 32'd100;
        seed = 16'h7777;
        poked = 1;
      end
      if (gocyc < 0 || cyc <= gocyc + v.stale) wr_ctrl_done = 1'b1;
      else if (cyc <= gocyc + v.stale + v.busyc) wr_ctrl_done = 1'b0;
      else begin
        wr_ctrl_done = 1'b1;
        if (upat < 0) upat = cyc;
      end
      case (v.fmode)
        1: wr_user_buffer_full = ($urandom_range(0, 9) < 4);
        2: begin
          wr_user_buffer_full = (hold > 0);
          if (hold > 0) hold--;
        end
        default: wr_user_buffer_full = 1'b0;
      endcase
      @(negedge clk_clk);
      if (wr_ctrl_go) begin
        gos++;
        if (gocyc < 0) gocyc = cyc;
        chk("go_base", wr_ctrl_write_base, v.base);
        chk("go_length", wr_ctrl_write_length, v.exp_lenw);
      end
      if (!busy) busylow++;
      if (gocyc >= 0 && wr_ctrl_write_base !== v.base) badbase++;
      if (wr_user_write_buffer) begin
        if (wr_user_buffer_full) viol++;
        chk("push_data", 32'(wr_user_buffer_input_data),
            32'(ref_word(v.seed, pushes)));
        got_q.push_back(wr_user_buffer_input_data);
        pushes++;
        lastpush = cyc;
        if (v.fmode == 2) begin
          pc++;
          if (pc == 2) begin pc = 0; hold = 3; end
        end
      end
      if (done) donecyc = cyc;
      @(posedge clk_clk); #1;
    end
    start = 1'b0;
    wr_user_buffer_full = 1'b0;
    wr_ctrl_done = 1'b1;
    if (v.exp_lenw == 0) expdone = 0;
    else expdone = ((upat > lastpush + 1) ? upat : lastpush + 1) + 1;
    chk("done_cycle", 32'(donecyc), 32'(expdone));
    chk("go_count", 32'(gos), (v.exp_lenw != 0) ? 32'd1 : 32'd0);
    chk("push_count", 32'(pushes), v.exp_words);
    chk("push_while_full", 32'(viol), 32'd0);
    chk("busy_dropout", 32'(busylow), 32'd0);
    chk("base_unstable", 32'(badbase), 32'd0);
    @(negedge clk_clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_width", 32'(done), 32'd0);
    chk("words_pushed", words_pushed, v.exp_words);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_go"}, 32'(wr_ctrl_go), 32'd0);
    chk({tag, "_wbuf"}, 32'(wr_user_write_buffer), 32'd0);
    chk({tag, "_data"}, 32'(wr_user_buffer_input_data), 32'd0);
    chk({tag, "_base"}, wr_ctrl_write_base, 32'd0);
    chk({tag, "_length"}, wr_ctrl_write_length, 32'd0);
    chk({tag, "_words"}, words_pushed, 32'd0);
    chk({tag, "_fixed"}, 32'(wr_ctrl_fixed_location), 32'd0);
  endtask

  initial begin
    logic [15:0] bexp[4];
    vec_t r;
    int seen;
    bexp = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    tbl[0] = '{32'h100, 32'd8, 16'h0010, 1, 3, 0, 1'b0, 32'd8, 32'd4};
    tbl[1] = '{32'h2000, 32'd16, 16'h0100, 1, 3, 2, 1'b0, 32'd16, 32'd8};
    tbl[2] = '{32'h300, 32'd7, 16'h0AAA, 0, 2, 0, 1'b0, 32'd6, 32'd3};
    tbl[3] = '{32'h400, 32'd0, 16'h1234, 0, 1, 0, 1'b0, 32'd0, 32'd0};
    tbl[4] = '{32'h500, 32'd8, 16'h0050, 2, 10, 0, 1'b0, 32'd8, 32'd4};
    tbl[5] = '{32'h600, 32'd8, 16'hFFFE, 1, 2, 1, 1'b0, 32'd8, 32'd4};
    tbl[6] = '{32'h700, 32'd20, 16'h0200, 1, 4, 0, 1'b1, 32'd20, 32'd10};
    tbl[7] = '{32'h800, 32'd1, 16'h4444, 0, 1, 0, 1'b0, 32'd0, 32'd0};

    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk_clk);
    #1 reset_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i]);
`ifndef SDRAM_PATTERN_LFSR_EN
      if (i == 0)
        for (int k = 0; k < 4; k++)
          chk("basic_word", 32'(got_q[k]), 32'(bexp[k]));
      if (i == 1) chk("bp_last_word", 32'(got_q[7]), 32'h0107);
      if (i == 5) chk("wrap_word", 32'(got_q[2]), 32'h0000);
`endif
    end

    for (int n = 0; n < 12; n++) begin
      r.base = $urandom & 32'hFFFF_FFFE;
      r.len = $urandom_range(0, 40);
      r.seed = 16'($urandom);
      r.stale = $urandom_range(0, 3);
      r.busyc = $urandom_range(1, 6);
      r.fmode = $urandom_range(0, 2);
      r.poke = 1'($urandom_range(0, 1));
      r.exp_lenw = (r.len / 2) * 2;
      r.exp_words = r.len / 2;
      xfer(r);
    end

    // reset in the middle of a stream
    @(posedge clk_clk); #1;
    base_addr = 32'h900;
    length_bytes = 32'd32;
    seed = 16'h0900;
    start = 1'b1;
    @(posedge clk_clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      wr_ctrl_done = (c < 1);
      @(negedge clk_clk);
      if (wr_user_write_buffer) seen++;
      @(posedge clk_clk); #1;
    end
    chk("midstream_pushes", 32'(seen), 32'd3);
    reset_reset = 1'b1;
    #1;
    chk_zero("midreset");
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    wr_ctrl_done = 1'b1;
    r = '{32'h900, 32'd8, 16'h0900, 1, 2, 0, 1'b0, 32'd8, 32'd4};
    xfer(r);
    chk("restart_first_word", 32'(got_q[0]), 32'h0900);

`ifdef SDRAM_PATTERN_LFSR_EN
    r = '{32'hA00, 32'd6, 16'h0001, 1, 2, 0, 1'b0, 32'd6, 32'd3};
    xfer(r);
    chk("lfsr_w0", 32'(got_q[0]), 32'h0001);
    chk("lfsr_w1", 32'(got_q[1]), 32'hB400);
    chk("lfsr_w2", 32'(got_q[2]), 32'h5A00);
    r = '{32'hB00, 32'd4, 16'h0000, 1, 2, 0, 1'b0, 32'd4, 32'd2};
    xfer(r);
    chk("lfsr_zero_seed", 32'(got_q[0]), 32'hACE1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
